// File: rtl/res_merge.sv
// Merges PID and CORDIC result words into one registered valid/ready stream.
// Each source has its own FIFO; a round-robin arbiter drains them one word per cycle.
module res_merge #(
    parameter int unsigned DW    = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] pid_data,
    input  logic          pid_valid,
    input  logic [DW-1:0] cordic_data,
    input  logic          cordic_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          pid_full,
    output logic          cordic_full,
    output logic          pid_ovf,
    output logic          cordic_ovf,
    input  logic          ovf_clr
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic {StEmpty, StHold} out_state_e;

    // Index 0 = PID, index 1 = CORDIC throughout.
    logic [DW-1:0] in_data [2];
    logic [1:0]    in_valid;
    logic [DW-1:0] mem_q [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    full_q;
    logic [1:0]    ovf_q;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    not_empty;

    logic          last_grant_q;
    logic          grant_src;
    logic          load_en;
    out_state_e    state_q, state_d;
    logic [DW-1:0] out_data_q;
    logic          out_src_q;

    assign in_data[0] = pid_data;
    assign in_data[1] = cordic_data;
    assign in_valid   = {cordic_valid, pid_valid};

    // Push is gated by the registered full flag, so a same-cycle pop never rescues a word.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            not_empty[i] = (cnt_q[i] != '0);
            push[i]      = in_valid[i] & ~full_q[i];
            cnt_d[i]     = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Round-robin arbiter: with both sources pending, grant the one not granted last.
    always_comb begin
        pop       = '0;
        grant_src = 1'b0;
        load_en   = (state_q == StEmpty) | out_ready;
        if (load_en) begin
            if (not_empty[0] && (!not_empty[1] || last_grant_q)) begin
                pop[0]    = 1'b1;
                grant_src = 1'b0;
            end else if (not_empty[1]) begin
                pop[1]    = 1'b1;
                grant_src = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            full_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                end
                cnt_q[i]  <= cnt_d[i];
                full_q[i] <= (cnt_d[i] == CW'(DEPTH));
                if (ovf_clr) begin
                    ovf_q[i] <= 1'b0;
                end else if (in_valid[i] && full_q[i]) begin
                    ovf_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_data[i];
            end
        end
    end

    // Output stage state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StEmpty;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (|pop) begin
                out_data_q   <= mem_q[grant_src][rd_ptr_q[grant_src]];
                out_src_q    <= grant_src;
                last_grant_q <= grant_src;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = (|pop) ? StHold : StEmpty;
        end
    end

    always_comb begin
        out_valid   = (state_q == StHold);
        out_data    = out_data_q;
        out_src     = out_src_q;
        pid_full    = full_q[0];
        cordic_full = full_q[1];
        pid_ovf     = ovf_q[0];
        cordic_ovf  = ovf_q[1];
    end

endmodule
